// File: rtl/mem_responder.sv
// Memory-side responder: RAM plus switch/LED I/O window behind a wait-state FSM.
// Define MEM_ERR_EN to add the memErr output flagging unmapped or illegal I/O accesses.
module mem_responder #(
  parameter int               WIDTH       = 16,
  parameter int               ADDR_BITS   = 10,
  parameter int               WAIT_STATES = 1,
  parameter logic [WIDTH-1:0] IO_BASE     = 16'hFF00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memReq,
  input  logic             memWe,
  input  logic [WIDTH-1:0] adrFromProc,
  input  logic [WIDTH-1:0] dataFromProc,
  output logic [WIDTH-1:0] dataToProc,
  output logic             memAck,
  output logic             memBusy,
  input  logic [WIDTH-1:0] ioIn,
  output logic [WIDTH-1:0] ioOut
`ifdef MEM_ERR_EN
  , output logic           memErr
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  localparam logic [WIDTH-1:0] IO_OUT_ADR = IO_BASE + WIDTH'(1);
  localparam logic [3:0]       WS_M1      = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] adr_q, adr_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] io_out_q, io_out_d;
  logic             ram_we;

  logic                 is_ram, is_io_in, is_io_out;
  logic [ADDR_BITS-1:0] ram_idx;

  // Decode always works on the latched address, never the live bus.
  assign is_ram    = adr_q < IO_BASE;
  assign is_io_in  = adr_q == IO_BASE;
  assign is_io_out = adr_q == IO_OUT_ADR;
  assign ram_idx   = adr_q[ADDR_BITS-1:0];

`ifdef MEM_ERR_EN
  logic err_q, err_d;
  assign memErr = err_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    ack_d    = 1'b0;
    rdata_d  = rdata_q;
    io_out_d = io_out_q;
    ram_we   = 1'b0;
`ifdef MEM_ERR_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (memReq) begin
          adr_d   = adrFromProc;
          we_d    = memWe;
          wdata_d = dataFromProc;
          cnt_d   = WS_M1;
          state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        ack_d   = 1'b1;
        state_d = S_IDLE;
        if (we_q) begin
          rdata_d = wdata_q;
          if (is_ram)         ram_we   = 1'b1;
          else if (is_io_out) io_out_d = wdata_q;
        end else begin
          if (is_ram)         rdata_d = mem[ram_idx];
          else if (is_io_in)  rdata_d = ioIn;
          else if (is_io_out) rdata_d = io_out_q;
          else                rdata_d = '0;
        end
`ifdef MEM_ERR_EN
        err_d = (!is_ram && !is_io_in && !is_io_out) || (we_q && is_io_in);
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      adr_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      io_out_q <= '0;
`ifdef MEM_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      io_out_q <= io_out_d;
`ifdef MEM_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  // RAM is never cleared; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) mem[ram_idx] <= wdata_q;
  end

  assign dataToProc = rdata_q;
  assign memAck     = ack_q;
  assign memBusy    = (state_q != S_IDLE);
  assign ioOut      = io_out_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: one instance with one wait state,
// a second with zero wait states for back-to-back throughput.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [15:0] adr_from_proc = '0, data_from_proc = '0, io_in = '0;
  logic [15:0] data_to_proc, io_out;
  logic        mem_ack, mem_busy;

  logic        mem_req0 = 1'b0, mem_we0 = 1'b0;
  logic [15:0] adr0 = '0, wdata0 = '0, io_in0 = '0;
  logic [15:0] data_to_proc0, io_out0;
  logic        mem_ack0, mem_busy0;

`ifdef MEM_ERR_EN
  logic mem_err, mem_err0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder #(.WIDTH(16), .ADDR_BITS(10), .WAIT_STATES(1), .IO_BASE(16'hFF00)) dut (
    .clk(clk), .reset(reset), .memReq(mem_req), .memWe(mem_we),
    .adrFromProc(adr_from_proc), .dataFromProc(data_from_proc),
    .dataToProc(data_to_proc), .memAck(mem_ack), .memBusy(mem_busy),
    .ioIn(io_in), .ioOut(io_out)
`ifdef MEM_ERR_EN
    , .memErr(mem_err)
`endif
  );

  mem_responder #(.WIDTH(16), .ADDR_BITS(10), .WAIT_STATES(0), .IO_BASE(16'hFF00)) dut0 (
    .clk(clk), .reset(reset), .memReq(mem_req0), .memWe(mem_we0),
    .adrFromProc(adr0), .dataFromProc(wdata0),
    .dataToProc(data_to_proc0), .memAck(mem_ack0), .memBusy(mem_busy0),
    .ioIn(io_in0), .ioOut(io_out0)
`ifdef MEM_ERR_EN
    , .memErr(mem_err0)
`endif
  );

  // Issues one request on the one-wait-state instance from a negedge and returns at the ack negedge.
  task automatic do_req(input logic we, input logic [15:0] adr, input logic [15:0] data,
                        output logic [15:0] rd, output int cycles, output int busy_n);
    mem_we = we; adr_from_proc = adr; data_from_proc = data; mem_req = 1'b1;
    cycles = 0; busy_n = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) mem_req = 1'b0;
      if (mem_busy) busy_n++;
    end while (!mem_ack && cycles < 20);
    rd = data_to_proc;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", mem_ack); end
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", mem_busy); end
    checks++; if (data_to_proc !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", data_to_proc); end
    checks++; if (io_out !== 16'h0) begin errors++; $display("FAIL reset_ioout got=%h exp=0000", io_out); end
    checks++; if ({mem_ack0, mem_busy0} !== 2'b00) begin errors++; $display("FAIL reset_dut0 got=%b exp=00", {mem_ack0, mem_busy0}); end
    reset = 1'b0;
  endtask

  task automatic test_ram_rw;
    logic [15:0] rd; int cyc, busy;
    do_req(1'b1, 16'h0010, 16'hBEEF, rd, cyc, busy);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL wr_latency got=%0d exp=3", cyc); end
    checks++; if (busy !== 2) begin errors++; $display("FAIL wr_busy got=%0d exp=2", busy); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL wr_echo got=%h exp=BEEF", rd); end
    @(negedge clk);
    checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse got=%b exp=0", mem_ack); end
    do_req(1'b0, 16'h0010, 16'h0000, rd, cyc, busy);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL rd_latency got=%0d exp=3", cyc); end
    checks++; if (busy !== 2) begin errors++; $display("FAIL rd_busy got=%0d exp=2", busy); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_data got=%h exp=BEEF", rd); end
  endtask

  task automatic test_alias;
    logic [15:0] rd; int cyc, busy;
    do_req(1'b1, 16'h0005, 16'h1234, rd, cyc, busy);
    do_req(1'b0, 16'h0405, 16'h0000, rd, cyc, busy);
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL alias got=%h exp=1234", rd); end
  endtask

  task automatic test_io;
    logic [15:0] rd; int cyc, busy;
    io_in = 16'h00A5;
    do_req(1'b0, 16'hFF00, 16'h0000, rd, cyc, busy);
    checks++; if (rd !== 16'h00A5) begin errors++; $display("FAIL io_in_read got=%h exp=00A5", rd); end
`ifdef MEM_ERR_EN
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL err_io_in got=%b exp=0", mem_err); end
`endif
    do_req(1'b1, 16'hFF01, 16'h0F0F, rd, cyc, busy);
    checks++; if (io_out !== 16'h0F0F) begin errors++; $display("FAIL io_out_write got=%h exp=0F0F", io_out); end
    do_req(1'b0, 16'hFF01, 16'h0000, rd, cyc, busy);
    checks++; if (rd !== 16'h0F0F) begin errors++; $display("FAIL io_out_read got=%h exp=0F0F", rd); end
    do_req(1'b0, 16'hFF07, 16'h0000, rd, cyc, busy);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL unmapped_read got=%h exp=0000", rd); end
`ifdef MEM_ERR_EN
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL err_unmapped got=%b exp=1", mem_err); end
`endif
    do_req(1'b1, 16'hFF00, 16'h5A5A, rd, cyc, busy);
    checks++; if (io_out !== 16'h0F0F) begin errors++; $display("FAIL io_in_write_discard got=%h exp=0F0F", io_out); end
`ifdef MEM_ERR_EN
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL err_write_io_in got=%b exp=1", mem_err); end
`endif
  endtask

  // Zero-wait instance with memReq held high: ack expected on every second negedge.
  task automatic test_back_to_back;
    int acks;
    logic exp_ack;
    for (int pass = 0; pass < 2; pass++) begin
      acks = 0;
      mem_we0 = (pass == 0); adr0 = 16'h0000; wdata0 = 16'hA000; mem_req0 = 1'b1;
      for (int cyc = 1; cyc <= 6; cyc++) begin
        @(negedge clk);
        exp_ack = (cyc % 2 == 0);
        checks++; if (mem_ack0 !== exp_ack) begin errors++; $display("FAIL b2b_ack pass=%0d cyc=%0d got=%b exp=%b", pass, cyc, mem_ack0, exp_ack); end
        checks++; if (mem_busy0 !== !exp_ack) begin errors++; $display("FAIL b2b_busy pass=%0d cyc=%0d got=%b exp=%b", pass, cyc, mem_busy0, !exp_ack); end
        if (mem_ack0) begin
          checks++; if (data_to_proc0 !== 16'hA000 + 16'(acks)) begin errors++; $display("FAIL b2b_data pass=%0d n=%0d got=%h exp=%h", pass, acks, data_to_proc0, 16'hA000 + 16'(acks)); end
          acks++;
          if (acks < 3) begin adr0 = 16'(acks); wdata0 = 16'hA000 + 16'(acks); end
          else mem_req0 = 1'b0;
        end
      end
      @(negedge clk);
      checks++; if ({mem_ack0, mem_busy0} !== 2'b00) begin errors++; $display("FAIL b2b_extra pass=%0d got=%b exp=00", pass, {mem_ack0, mem_busy0}); end
      checks++; if (acks !== 3) begin errors++; $display("FAIL b2b_count pass=%0d got=%0d exp=3", pass, acks); end
    end
  endtask

  task automatic test_reset_in_flight;
    logic [15:0] rd; int cyc, busy;
    logic saw_ack;
    do_req(1'b1, 16'h0003, 16'h1111, rd, cyc, busy);
    mem_we = 1'b1; adr_from_proc = 16'h0003; data_from_proc = 16'h7777; mem_req = 1'b1;
    @(negedge clk);
    mem_req = 1'b0;
    checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL rif_wait_busy got=%b exp=1", mem_busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (io_out !== 16'h0000) begin errors++; $display("FAIL rif_ioout got=%h exp=0000", io_out); end
    checks++; if (data_to_proc !== 16'h0000) begin errors++; $display("FAIL rif_data got=%h exp=0000", data_to_proc); end
    saw_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mem_ack || mem_busy) saw_ack = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_ack !== 1'b0) begin errors++; $display("FAIL rif_dropped got=%b exp=0", saw_ack); end
    do_req(1'b0, 16'h0003, 16'h0000, rd, cyc, busy);
    checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL rif_ram_kept got=%h exp=1111", rd); end
  endtask

  task automatic test_latched_inputs;
    logic [15:0] rd; int cyc, busy;
    do_req(1'b1, 16'h0021, 16'h3333, rd, cyc, busy);
    mem_we = 1'b1; adr_from_proc = 16'h0020; data_from_proc = 16'hAAAA; mem_req = 1'b1;
    @(negedge clk);
    mem_we = 1'b0; adr_from_proc = 16'h0021; data_from_proc = 16'h5555;
    checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL lat_ack_wait got=%b exp=0", mem_ack); end
    @(negedge clk);
    mem_req = 1'b0;
    checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL lat_ack_access got=%b exp=0", mem_ack); end
    @(negedge clk);
    checks++; if ({mem_ack, data_to_proc} !== {1'b1, 16'hAAAA}) begin errors++; $display("FAIL lat_echo got=%b/%h exp=1/AAAA", mem_ack, data_to_proc); end
    do_req(1'b0, 16'h0020, 16'h0000, rd, cyc, busy);
    checks++; if (rd !== 16'hAAAA) begin errors++; $display("FAIL lat_rd20 got=%h exp=AAAA", rd); end
    do_req(1'b0, 16'h0021, 16'h0000, rd, cyc, busy);
    checks++; if (rd !== 16'h3333) begin errors++; $display("FAIL lat_rd21 got=%h exp=3333", rd); end
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_alias();
    test_io();
    test_back_to_back();
    test_reset_in_flight();
    test_latched_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
